// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2^MUL_BITS shift-add multiplier,
// DIV_BITS-per-cycle restoring divider, result handshake with backpressure and kill.
module muldiv_iter #(
    parameter int XLEN      = 64,
    parameter int MUL_BITS  = 2,
    parameter int DIV_BITS  = 1,
    parameter int EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    output logic            ready,
    input  logic [2:0]      funct3,
    input  logic            is_op32,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            kill,
    output logic            rvalid,
    input  logic            rready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state_reg, state_next;

    logic [2:0]        f3_reg;
    logic              w_reg, s1_reg, s2_reg;
    logic [CW-1:0]     count_reg;
    logic [2*XLEN-1:0] acc_reg, mcand_reg;
    logic [XLEN-1:0]   mplier_reg, quo_reg, rem_reg, div_reg, result_reg;

    function automatic logic [XLEN-1:0] fix_w(input logic w, input logic [XLEN-1:0] x);
        return w ? XLEN'($signed(x[31:0])) : x;
    endfunction

    // ---------------- request preparation ----------------
    logic            is_w, is_div, zext_w, signed1, signed2, sign1, sign2;
    logic            div_zero, div_ovf, mul_zero, special;
    logic [XLEN-1:0] ext1, ext2, abs1, abs2, int_min, special_res;

    always_comb begin
        is_w    = (XLEN == 64) && is_op32;
        is_div  = funct3[2];
        zext_w  = is_div && funct3[0];
        ext1    = op1;
        ext2    = op2;
        if (is_w) begin
            ext1 = zext_w ? XLEN'(op1[31:0]) : XLEN'($signed(op1[31:0]));
            ext2 = zext_w ? XLEN'(op2[31:0]) : XLEN'($signed(op2[31:0]));
        end
        signed1 = is_div ? !funct3[0] : (funct3[1:0] != 2'b11);
        signed2 = is_div ? !funct3[0] : !funct3[1];
        sign1   = signed1 && ext1[XLEN-1];
        sign2   = signed2 && ext2[XLEN-1];
        abs1    = sign1 ? -ext1 : ext1;
        abs2    = sign2 ? -ext2 : ext2;
        int_min = is_w ? ~XLEN'(32'h7FFF_FFFF) : {1'b1, {(XLEN-1){1'b0}}};

        div_zero = is_div && (ext2 == '0);
        div_ovf  = is_div && !funct3[0] && (ext1 == int_min) && (ext2 == '1);
        mul_zero = (EARLY_OUT != 0) && !is_div && ((abs1 == '0) || (abs2 == '0));
        special  = div_zero || div_ovf || mul_zero;

        special_res = '0;
        if (div_zero)
            special_res = funct3[1] ? ext1 : '1;
        else if (div_ovf)
            special_res = funct3[1] ? '0 : int_min;
        special_res = fix_w(is_w, special_res);
    end

    // ---------------- one Calc step ----------------
    logic [2*XLEN-1:0] pp [MUL_BITS];

    generate
        for (genvar gi = 0; gi < MUL_BITS; gi++) begin : g_pp
            assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
        end
    endgenerate

    logic [2*XLEN-1:0] acc_step, prod_fix;
    logic [XLEN-1:0]   rem_t, quo_t, q_fix, r_fix, sel_res, fin_res;
    logic [XLEN:0]     trial, diff;

    always_comb begin
        acc_step = acc_reg;
        for (int b = 0; b < MUL_BITS; b++)
            acc_step = acc_step + pp[b];

        // rem < divisor always holds, so diff[XLEN] is a reliable borrow flag
        rem_t = rem_reg;
        quo_t = quo_reg;
        trial = '0;
        diff  = '0;
        for (int k = 0; k < DIV_BITS; k++) begin
            trial = {rem_t, quo_t[XLEN-1]};
            diff  = trial - {1'b0, div_reg};
            rem_t = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
            quo_t = {quo_t[XLEN-2:0], !diff[XLEN]};
        end

        prod_fix = (s1_reg ^ s2_reg) ? -acc_step : acc_step;
        q_fix    = (s1_reg ^ s2_reg) ? -quo_t : quo_t;
        r_fix    = s1_reg ? -rem_t : rem_t;
        if (f3_reg[2])
            sel_res = f3_reg[1] ? r_fix : q_fix;
        else
            sel_res = (f3_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        fin_res = fix_w(w_reg, sel_res);
    end

    // ---------------- control FSM ----------------
    logic accept, calc_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        calc_last  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (valid && !kill) begin
                    accept     = 1'b1;
                    state_next = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (kill)
                    state_next = IDLE;
                else if (count_reg == CW'(1)) begin
                    calc_last  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (kill || rready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f3_reg     <= '0;
            w_reg      <= 1'b0;
            s1_reg     <= 1'b0;
            s2_reg     <= 1'b0;
            count_reg  <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            quo_reg    <= '0;
            rem_reg    <= '0;
            div_reg    <= '0;
            result_reg <= '0;
        end else if (accept) begin
            f3_reg     <= funct3;
            w_reg      <= is_w;
            s1_reg     <= sign1;
            s2_reg     <= sign2;
            if (is_div)
                count_reg <= is_w ? CW'(32 / DIV_BITS) : CW'(XLEN / DIV_BITS);
            else
                count_reg <= is_w ? CW'(32 / MUL_BITS) : CW'(XLEN / MUL_BITS);
            acc_reg    <= '0;
            mcand_reg  <= (2*XLEN)'(abs1);
            mplier_reg <= abs2;
            // W dividends are left-aligned so the quotient lands in the low 32 bits
            quo_reg    <= is_w ? (abs1 << 32) : abs1;
            rem_reg    <= '0;
            div_reg    <= abs2;
            if (special)
                result_reg <= special_res;
        end else if (state_reg == CALC) begin
            count_reg  <= count_reg - CW'(1);
            acc_reg    <= acc_step;
            mcand_reg  <= mcand_reg << MUL_BITS;
            mplier_reg <= mplier_reg >> MUL_BITS;
            quo_reg    <= quo_t;
            rem_reg    <= rem_t;
            if (calc_last)
                result_reg <= fin_res;
        end
    end

    assign ready  = (state_reg == IDLE);
    assign rvalid = (state_reg == DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: two instances (DIV_BITS=1 and DIV_BITS=2) share
// operand, kill and rready inputs; each has its own valid.
module tb_muldiv_iter;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic        is_op32 = 1'b0, kill = 1'b0, rready = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [63:0] op1 = '0, op2 = '0;
    logic        ready_a, rvalid_a, ready_b, rvalid_b;
    logic [63:0] result_a, result_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.XLEN(64), .MUL_BITS(2), .DIV_BITS(1), .EARLY_OUT(1)) u_dut_a (
        .clk(clk), .rst(rst), .valid(valid_a), .ready(ready_a), .funct3(funct3),
        .is_op32(is_op32), .op1(op1), .op2(op2), .kill(kill), .rvalid(rvalid_a),
        .rready(rready), .result(result_a)
    );

    muldiv_iter #(.XLEN(64), .MUL_BITS(2), .DIV_BITS(2), .EARLY_OUT(1)) u_dut_b (
        .clk(clk), .rst(rst), .valid(valid_b), .ready(ready_b), .funct3(funct3),
        .is_op32(is_op32), .op1(op1), .op2(op2), .kill(kill), .rvalid(rvalid_b),
        .rready(rready), .result(result_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge with the chosen instance idle; returns in cycle T+1.
    task automatic issue(input bit sel, input logic [2:0] f, input bit w,
                         input logic [63:0] a, input logic [63:0] b);
        funct3 = f; is_op32 = w; op1 = a; op2 = b;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        step();
        valid_a = 1'b0; valid_b = 1'b0;
    endtask

    // lat = k means rvalid first seen in cycle T+k; gives up at 200.
    task automatic wait_res(input bit sel, output int lat, output logic [63:0] res);
        lat = 1;
        while (((sel ? rvalid_b : rvalid_a) !== 1'b1) && lat < 200) begin
            step();
            lat++;
        end
        res = sel ? result_b : result_a;
    endtask

    task automatic consume();
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready_a); end
        n_checks++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", rvalid_a); end
        n_checks++; if (result_a !== 64'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", result_a); end
        n_checks++; if (ready_b !== 1'b1) begin n_fail++; $display("FAIL reset_ready_b got %b want 1", ready_b); end
        rst = 1'b1;
        step();
        n_checks++; if (ready_a !== 1'b1 || rvalid_a !== 1'b0) begin n_fail++; $display("FAIL post_reset ready=%b rvalid=%b want 1/0", ready_a, rvalid_a); end
        $display("reset done");
    endtask

    task automatic test_mul();
        int lat; logic [63:0] res;
        issue(0, F_MUL, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7); wait_res(0, lat, res);
        $display("MUL    -3*7 -> %h lat %0d", res, lat);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mul got %h want ffffffffffffffeb", res); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mul_lat got %0d want 33", lat); end
        consume();
        issue(0, F_MULHU, 0, '1, '1); wait_res(0, lat, res);
        $display("MULHU  ~0*~0 -> %h lat %0d", res, lat);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL mulhu got %h want fffffffffffffffe", res); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mulhu_lat got %0d want 33", lat); end
        consume();
        issue(0, F_MULHSU, 0, '1, 64'd2); wait_res(0, lat, res);
        $display("MULHSU -1*2 -> %h lat %0d", res, lat);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL mulhsu got %h want ffffffffffffffff", res); end
        consume();
        issue(0, F_MULH, 0, 64'h8000_0000_0000_0000, 64'd4); wait_res(0, lat, res);
        $display("MULH   min*4 -> %h lat %0d", res, lat);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL mulh got %h want fffffffffffffffe", res); end
        consume();
        issue(0, F_MUL, 1, 64'h1_0000_0003, 64'h8000_0000); wait_res(0, lat, res);
        $display("MULW   -> %h lat %0d", res, lat);
        n_checks++; if (res !== 64'hFFFF_FFFF_8000_0000) begin n_fail++; $display("FAIL mulw got %h want ffffffff80000000", res); end
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL mulw_lat got %0d want 17", lat); end
        consume();
        issue(0, F_MUL, 0, 64'h1234, 64'd0); wait_res(0, lat, res);
        $display("MUL    x*0 -> %h lat %0d", res, lat);
        n_checks++; if (res !== 64'd0) begin n_fail++; $display("FAIL mul_zero got %h want 0", res); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL mul_zero_lat got %0d want 1", lat); end
        consume();
    endtask

    task automatic test_div_special();
        int lat; logic [63:0] res;
        issue(0, F_DIV, 0, 64'h8000_0000_0000_0000, '1); wait_res(0, lat, res);
        $display("DIV    min/-1 -> %h lat %0d", res, lat);
        n_checks++; if (res !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL div_ovf got %h want 8000000000000000", res); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL div_ovf_lat got %0d want 1", lat); end
        consume();
        issue(0, F_REM, 0, 64'h8000_0000_0000_0000, '1); wait_res(0, lat, res);
        $display("REM    min/-1 -> %h lat %0d", res, lat);
        n_checks++; if (res !== 64'd0) begin n_fail++; $display("FAIL rem_ovf got %h want 0", res); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL rem_ovf_lat got %0d want 1", lat); end
        consume();
        issue(0, F_DIVU, 0, 64'd12345, 64'd0); wait_res(0, lat, res);
        $display("DIVU   x/0 -> %h lat %0d", res, lat);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL divu_zero got %h want ffffffffffffffff", res); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL divu_zero_lat got %0d want 1", lat); end
        consume();
        issue(0, F_REM, 1, 64'h1_8000_0001, 64'd0); wait_res(0, lat, res);
        $display("REMW   x/0 -> %h lat %0d", res, lat);
        n_checks++; if (res !== 64'hFFFF_FFFF_8000_0001) begin n_fail++; $display("FAIL remw_zero got %h want ffffffff80000001", res); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL remw_zero_lat got %0d want 1", lat); end
        consume();
    endtask

    task automatic test_div();
        int lat; logic [63:0] res;
        issue(0, F_DIV, 0, 64'd100, '1 - 64'd6); wait_res(0, lat, res);
        $display("DIV    100/-7 -> %h lat %0d", res, lat);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFF2) begin n_fail++; $display("FAIL div got %h want fffffffffffffff2", res); end
        n_checks++; if (lat !== 65) begin n_fail++; $display("FAIL div_lat got %0d want 65", lat); end
        consume();
        issue(0, F_REMU, 0, 64'd100, 64'd7); wait_res(0, lat, res);
        $display("REMU   100%%7 -> %h lat %0d", res, lat);
        n_checks++; if (res !== 64'd2) begin n_fail++; $display("FAIL remu got %h want 2", res); end
        consume();
    endtask

    task automatic test_div_w();
        int lat; logic [63:0] res;
        issue(1, F_DIVU, 1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2); wait_res(1, lat, res);
        $display("DIVUW  -> %h lat %0d", res, lat);
        n_checks++; if (res !== 64'h0000_0000_7FFF_FFFF) begin n_fail++; $display("FAIL divuw got %h want 000000007fffffff", res); end
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL divuw_lat got %0d want 17", lat); end
        consume();
        issue(1, F_REM, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2); wait_res(1, lat, res);
        $display("REMW   -7%%2 -> %h lat %0d", res, lat);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL remw got %h want ffffffffffffffff", res); end
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL remw_lat got %0d want 17", lat); end
        consume();
        issue(1, F_DIV, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2); wait_res(1, lat, res);
        $display("DIVW   -7/2 -> %h lat %0d", res, lat);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL divw got %h want fffffffffffffffd", res); end
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL divw_lat got %0d want 17", lat); end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat; logic [63:0] res;
        issue(0, F_MUL, 0, 64'd6, 64'd7); wait_res(0, lat, res);
        $display("MUL    6*7 -> %h lat %0d (held)", res, lat);
        funct3 = F_MUL; is_op32 = 1'b0; op1 = 64'd3; op2 = 64'd5; valid_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (result_a !== 64'd42) begin n_fail++; $display("FAIL hold_result cyc %0d got %h want 2a", i, result_a); end
            n_checks++; if (ready_a !== 1'b0 || rvalid_a !== 1'b1) begin n_fail++; $display("FAIL hold_flags cyc %0d ready=%b rvalid=%b want 0/1", i, ready_a, rvalid_a); end
            step();
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        n_checks++; if (ready_a !== 1'b1 || rvalid_a !== 1'b0) begin n_fail++; $display("FAIL after_hs ready=%b rvalid=%b want 1/0", ready_a, rvalid_a); end
        step();
        valid_a = 1'b0;
        wait_res(0, lat, res);
        $display("MUL    3*5 -> %h lat %0d (back-to-back)", res, lat);
        n_checks++; if (res !== 64'd15) begin n_fail++; $display("FAIL b2b got %h want f", res); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_lat got %0d want 33", lat); end
        consume();
    endtask

    task automatic test_kill();
        int lat; logic [63:0] res; bit seen;
        issue(0, F_DIV, 0, 64'd1000, 64'd3);
        step(); step();
        n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL calc_ready got %b want 0", ready_a); end
        step(); step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        n_checks++; if (ready_a !== 1'b1 || rvalid_a !== 1'b0) begin n_fail++; $display("FAIL kill_calc ready=%b rvalid=%b want 1/0", ready_a, rvalid_a); end
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (rvalid_a === 1'b1) seen = 1'b1;
            step();
        end
        $display("DIV    killed at T+5, late rvalid seen=%b", seen);
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL kill_no_result got %b want 0", seen); end
        issue(0, F_MUL, 0, 64'd6, 64'd7); wait_res(0, lat, res);
        $display("MUL    6*7 after kill -> %h lat %0d", res, lat);
        n_checks++; if (res !== 64'd42) begin n_fail++; $display("FAIL mul_after_kill got %h want 2a", res); end
        // kill and rready together while Done
        kill = 1'b1; rready = 1'b1;
        step();
        kill = 1'b0; rready = 1'b0;
        $display("kill+rready in Done -> ready=%b rvalid=%b", ready_a, rvalid_a);
        n_checks++; if (ready_a !== 1'b1 || rvalid_a !== 1'b0) begin n_fail++; $display("FAIL kill_done ready=%b rvalid=%b want 1/0", ready_a, rvalid_a); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        issue(0, F_MUL, 0, 64'd5, 64'd9);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b0;
        #1;
        $display("rst mid-Calc -> ready=%b rvalid=%b result=%h", ready_a, rvalid_a, result_a);
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %b want 1", ready_a); end
        n_checks++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rvalid got %b want 0", rvalid_a); end
        n_checks++; if (result_a !== 64'd0) begin n_fail++; $display("FAIL rst_mid_result got %h want 0", result_a); end
        step();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rvalid_a === 1'b1) seen = 1'b1;
            step();
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_discard got %b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div_special();
        test_div();
        test_div_w();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
